// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit bit-stuffing encoder.
package usb_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STUFF,
    EOP_SE0,
    EOP_J
  } tx_state_e;

  typedef enum logic [1:0] {
    LINE_HOLD,
    LINE_TOGGLE,
    LINE_SE0,
    LINE_IDLE
  } line_cmd_e;

  localparam logic [2:0] STUFF_LIMIT  = 3'd6;
  localparam logic [2:0] EOP_SE0_BITS = 3'd2;

  // {dp, dm} line levels for a full-speed idle polarity
  localparam logic [1:0] LVL_J_FS = 2'b10;
  localparam logic [1:0] LVL_K_FS = 2'b01;
  localparam logic [1:0] LVL_SE0  = 2'b00;

  function automatic logic [1:0] j_level(input logic idle_dp);
    return idle_dp ? LVL_J_FS : LVL_K_FS;
  endfunction

endpackage

// File: rtl/tx_nrzi_line.sv
// dp/dm line registers: NRZI toggle, SE0 and J drive, updated only on bit_strobe.
module tx_nrzi_line
  import usb_tx_pkg::*;
#(
  parameter logic IDLE_DP = 1'b1
) (
  input  logic      clk,
  input  logic      n_rst,
  input  logic      bit_strobe,
  input  line_cmd_e cmd,
  output logic      dp_out,
  output logic      dm_out
);

  localparam logic [1:0] LVL_J = j_level(IDLE_DP);

  logic [1:0] line_d, line_q;

  always_comb begin
    line_d = line_q;
    if (bit_strobe) begin
      case (cmd)
        LINE_TOGGLE: line_d = ~line_q;
        LINE_SE0:    line_d = LVL_SE0;
        LINE_IDLE:   line_d = LVL_J;
        default:     line_d = line_q;
      endcase
    end
  end

  // Reset returns the line to J at once, aborting any packet without EOP
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) line_q <= LVL_J;
    else        line_q <= line_d;
  end

  assign {dp_out, dm_out} = line_q;

endmodule

// File: rtl/tx_bit_stuff_encoder.sv
// USB transmit serializer: LSB-first shift, bit stuffing after six 1s, NRZI, EOP.
// Optional TX_STUFF_CNT_EN adds a saturating stuff_cnt output.
module tx_bit_stuff_encoder
  import usb_tx_pkg::*;
#(
  parameter logic IDLE_DP = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       shift_stall,
  output logic       dp_out,
  output logic       dm_out,
  output logic       busy,
  output logic       tx_err
`ifdef TX_STUFF_CNT_EN
  ,
  output logic [7:0] stuff_cnt
`endif
);

  tx_state_e  state_d, state_q;
  logic [7:0] shift_d, shift_q;
  logic       last_d, last_q;
  logic [2:0] ones_d, ones_q;
  logic [2:0] bit_idx_d, bit_idx_q;
  logic       stuff_now, byte_end, accept_idle, accept_next;
  line_cmd_e  line_cmd;

  assign stuff_now = shift_q[0] && (ones_q == STUFF_LIMIT - 3'd1);
  // bit_idx has wrapped to 0 when a stuff bit follows the 8th data bit
  assign byte_end  = bit_strobe &&
                     (((state_q == SHIFT) && (bit_idx_q == 3'd7) && !stuff_now) ||
                      ((state_q == STUFF) && (bit_idx_q == 3'd0)));
  assign accept_idle = (state_q == IDLE) && tx_valid;
  assign accept_next = byte_end && !last_q && tx_valid;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      last_q    <= 1'b0;
      ones_q    <= 3'd0;
      bit_idx_q <= 3'd0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      ones_q    <= ones_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // bit_idx doubles as the SE0 symbol counter during EOP
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    last_d    = last_q;
    ones_d    = ones_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      IDLE: begin
        if (tx_valid) begin
          shift_d   = tx_data;
          last_d    = tx_last;
          ones_d    = 3'd0;
          bit_idx_d = 3'd0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_strobe) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          ones_d    = shift_q[0] ? ones_q + 3'd1 : 3'd0;
          if (stuff_now) state_d = STUFF;
        end
      end
      STUFF: begin
        if (bit_strobe) begin
          ones_d  = 3'd0;
          state_d = SHIFT;
        end
      end
      EOP_SE0: begin
        if (bit_strobe) begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == EOP_SE0_BITS - 3'd1) begin
            bit_idx_d = 3'd0;
            state_d   = EOP_J;
          end
        end
      end
      EOP_J: begin
        if (bit_strobe) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (byte_end) begin
      bit_idx_d = 3'd0;
      if (accept_next) begin
        shift_d = tx_data;
        last_d  = tx_last;
        state_d = SHIFT;
      end else begin
        state_d = EOP_SE0;
      end
    end
  end

  always_comb begin
    line_cmd    = LINE_HOLD;
    tx_ready    = n_rst && (accept_idle || accept_next);
    tx_err      = byte_end && !last_q && !tx_valid;
    busy        = (state_q != IDLE);
    shift_stall = (state_q == STUFF);
    case (state_q)
      SHIFT:   line_cmd = shift_q[0] ? LINE_HOLD : LINE_TOGGLE;
      STUFF:   line_cmd = LINE_TOGGLE;
      EOP_SE0: line_cmd = LINE_SE0;
      EOP_J:   line_cmd = LINE_IDLE;
      default: line_cmd = LINE_HOLD;
    endcase
  end

  tx_nrzi_line #(
    .IDLE_DP (IDLE_DP)
  ) u_line (
    .clk        (clk),
    .n_rst      (n_rst),
    .bit_strobe (bit_strobe),
    .cmd        (line_cmd),
    .dp_out     (dp_out),
    .dm_out     (dm_out)
  );

`ifdef TX_STUFF_CNT_EN
  logic [7:0] stuff_cnt_d, stuff_cnt_q;

  always_comb begin
    stuff_cnt_d = stuff_cnt_q;
    if (accept_idle)
      stuff_cnt_d = 8'd0;
    else if ((state_q == STUFF) && bit_strobe && (stuff_cnt_q != 8'hFF))
      stuff_cnt_d = stuff_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) stuff_cnt_q <= 8'd0;
    else        stuff_cnt_q <= stuff_cnt_d;
  end

  assign stuff_cnt = stuff_cnt_q;
`else
  // No stuff-bit counter in this build.
`endif

endmodule

// File: tb/tb_tx_bit_stuff_encoder.sv
// Scoreboard bench for tx_bit_stuff_encoder: directed packets, per-strobe line symbols.
`timescale 1ns/1ps
module tb_tx_bit_stuff_encoder;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       bit_strobe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_last;
  logic       tx_ready;
  logic       shift_stall;
  logic       dp_out;
  logic       dm_out;
  logic       busy;
  logic       tx_err;
`ifdef TX_STUFF_CNT_EN
  logic [7:0] stuff_cnt;
`endif

  typedef struct packed {
    logic [1:0] line;
    logic       stall;
    logic       bsy;
  } exp_t;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } byte_t;

  int    errors  = 0;
  int    checks  = 0;
  int    nstrobe = 0;
  int    mcount  = 0;
  exp_t  line_q[$];
  int    rdy_q[$];
  int    err_q[$];
  byte_t pend[$];

  always #5 clk = ~clk;

  tx_bit_stuff_encoder dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bit_strobe  (bit_strobe),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_last     (tx_last),
    .tx_ready    (tx_ready),
    .shift_stall (shift_stall),
    .dp_out      (dp_out),
    .dm_out      (dm_out),
    .busy        (busy),
    .tx_err      (tx_err)
`ifdef TX_STUFF_CNT_EN
    ,
    .stuff_cnt   (stuff_cnt)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: line/stall/busy after every strobe edge, ready/err pulses by strobe index
  initial begin
    logic st;
    exp_t e;
    forever begin
      @(posedge clk);
      st = bit_strobe;
      if (st) mcount++;
      @(negedge clk);
      if (st) begin
        if (line_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL line: strobe %0d had no expected symbol", mcount - 1);
        end else begin
          e = line_q.pop_front();
          check($sformatf("line/stall/busy after strobe %0d", mcount - 1),
                {28'd0, dp_out, dm_out, shift_stall, busy},
                {28'd0, e.line, e.stall, e.bsy});
        end
      end
      if (tx_ready) begin
        if (rdy_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_ready: unexpected pulse at strobe %0d, expected none", mcount);
        end else begin
          check("tx_ready strobe index", mcount, rdy_q.pop_front());
        end
      end
      if (tx_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_err: unexpected pulse at strobe %0d, expected none", mcount);
        end else begin
          check("tx_err strobe index", mcount, err_q.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic present_next();
    byte_t b;
    if (pend.size() > 0) begin
      b        = pend.pop_front();
      tx_data  = b.d;
      tx_last  = b.l;
      tx_valid = 1'b1;
    end else begin
      tx_data  = 8'h00;
      tx_last  = 1'b0;
      tx_valid = 1'b0;
    end
  endtask

  task automatic tick();
    logic hs;
    @(negedge clk);
    hs = tx_ready;
    @(posedge clk);
    #1;
    bit_strobe = 1'b0;
    if (hs) present_next();
  endtask

  task automatic strobe(input byte ch, input byte st, input byte bz);
    exp_t e;
    e.line  = (ch == "K") ? 2'b01 : ((ch == "0") ? 2'b00 : 2'b10);
    e.stall = (st == "1");
    e.bsy   = (bz == "1");
    line_q.push_back(e);
    bit_strobe = 1'b1;
    nstrobe++;
    tick();
    repeat (3) tick();
  endtask

  task automatic drained(input string tag);
    check({tag, " line queue drained"},  line_q.size(), 0);
    check({tag, " ready queue drained"}, rdy_q.size(),  0);
    check({tag, " err queue drained"},   err_q.size(),  0);
  endtask

  // Strings give the symbol, stall and busy seen after each strobe, starting at the load strobe
  task automatic run_pkt(input string tag, input string ln, input string st, input string bz,
                         input int rdy1, input int err_at);
    int base;
    base = nstrobe;
    rdy_q.push_back(base);
    if (rdy1 >= 0)   rdy_q.push_back(base + rdy1);
    if (err_at >= 0) err_q.push_back(base + err_at);
    present_next();
    for (int i = 0; i < ln.len(); i++) strobe(ln[i], st[i], bz[i]);
    drained(tag);
  endtask

  initial begin
    n_rst      = 1'b0;
    bit_strobe = 1'b0;
    tx_data    = 8'hA5;
    tx_last    = 1'b0;
    tx_valid   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset dp_out",      {31'd0, dp_out},      32'd1);
    check("reset dm_out",      {31'd0, dm_out},      32'd0);
    check("reset busy",        {31'd0, busy},        32'd0);
    check("reset shift_stall", {31'd0, shift_stall}, 32'd0);
    check("reset tx_ready",    {31'd0, tx_ready},    32'd0);
    check("reset tx_err",      {31'd0, tx_err},      32'd0);
`ifdef TX_STUFF_CNT_EN
    check("reset stuff_cnt",   {24'd0, stuff_cnt},   32'd0);
`endif
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) tick();

    // 0x00 last: eight toggles, SE0 x2, J
    pend.push_back({8'h00, 1'b1});
    run_pkt("byte00", "JKJKJKJKJ00JJ", "0000000000000", "1111111111100", -1, -1);

    // 0xFF last: six held ones, stuff toggle, two held ones, EOP
    pend.push_back({8'hFF, 1'b1});
    run_pkt("byteFF", "JJJJJJJKKK00JJ", "00000010000000", "11111111111100", -1, -1);

    // 0x80 then 0xFF: the run of six ones spans the byte boundary
    pend.push_back({8'h80, 1'b0});
    pend.push_back({8'hFF, 1'b1});
    run_pkt("byte80FF", "JKJKJKJKKKKKKKJJJJ00JJ", "0000000000000100000000",
            "1111111111111111111100", 8, -1);

    // 0x55 with last=0 and no follow-up byte: underrun then EOP
    pend.push_back({8'h55, 1'b0});
    run_pkt("underrun", "JJKKJJKKJ00JJ", "0000000000000", "1111111111100", -1, 8);

    // Reset during bit 4 of 0x08 while the line is at K
    rdy_q.push_back(nstrobe);
    pend.push_back({8'h08, 1'b1});
    present_next();
    strobe("J", "0", "1");
    strobe("K", "0", "1");
    strobe("J", "0", "1");
    strobe("K", "0", "1");
    strobe("K", "0", "1");
    n_rst = 1'b0;
    #1;
    check("abort dp_out",      {31'd0, dp_out},      32'd1);
    check("abort dm_out",      {31'd0, dm_out},      32'd0);
    check("abort busy",        {31'd0, busy},        32'd0);
    check("abort shift_stall", {31'd0, shift_stall}, 32'd0);
    check("abort tx_ready",    {31'd0, tx_ready},    32'd0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    strobe("J", "0", "0");
    strobe("J", "0", "0");
    drained("abort");

`ifdef TX_STUFF_CNT_EN
    // 0xFF, 0xFF: one stuff bit per byte
    pend.push_back({8'hFF, 1'b0});
    pend.push_back({8'hFF, 1'b1});
    run_pkt("stuffcnt", "JJJJJJJKKKKKKKJJJJJ00JJ", "00000010000001000000000",
            "11111111111111111111100", 9, -1);
    check("stuff_cnt at EOP", {24'd0, stuff_cnt}, 32'd2);
`endif

    repeat (4) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
